// File: rtl/conv_mc_engine_if.sv
// Bus between the feature-map buffer / controller and conv_mc_engine:
// launch handshake, packed ifm/kernel/bias operands and the packed ofm result.
interface conv_mc_engine_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BUF_WIDTH   = 26,
  parameter int unsigned MAP_SIZE    = 32,
  parameter int unsigned PADDING     = 1,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned IN_CH       = 4
);
  localparam int unsigned P   = MAP_SIZE + 2 * PADDING;
  localparam int unsigned OUT = (P - KERNEL_SIZE) / STRIDE + 1;

  logic                                        start;
  logic [IN_CH*P*P*DATA_WIDTH-1:0]             ifm;
  logic [IN_CH*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel;
  logic [2*DATA_WIDTH-1:0]                     bias;
  logic [OUT*OUT*BUF_WIDTH-1:0]                ofm;
  logic                                        idle;
  logic                                        finish;

  modport master (output start, ifm, kernel, bias, input ofm, idle, finish);
  modport slave  (input start, ifm, kernel, bias, output ofm, idle, finish);
endinterface

// File: rtl/conv_mc_engine.sv
// Multi-channel strided KxK convolution: one full window dot product per cycle,
// channel-accumulated with bias. Optional macro CONV_RELU_EN clamps stored ofm at 0.
module conv_mc_engine #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BUF_WIDTH   = 26,
  parameter int unsigned MAP_SIZE    = 32,
  parameter int unsigned PADDING     = 1,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned IN_CH       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_mc_engine_if.slave  bus
);
  localparam int unsigned P      = MAP_SIZE + 2 * PADDING;
  localparam int unsigned K      = KERNEL_SIZE;
  localparam int unsigned OUT    = (P - K) / STRIDE + 1;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned BW     = BUF_WIDTH;
  localparam int unsigned RCW    = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int unsigned CHW    = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int unsigned IFM_IW = $clog2(IN_CH * P * P * DW);
  localparam int unsigned KER_IW = (IN_CH * K * K * DW > 1) ? $clog2(IN_CH * K * K * DW) : 1;
  localparam int unsigned OFM_IW = (OUT * OUT * BW > 1) ? $clog2(OUT * OUT * BW) : 1;

  localparam logic [RCW-1:0] LAST_RC = RCW'(OUT - 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(IN_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     state;
  logic [RCW-1:0]             row;
  logic [RCW-1:0]             col;
  logic [CHW-1:0]             ch;
  logic signed [BW-1:0]       acc;
  logic                       idle_q;
  logic                       finish_q;
  logic [OUT*OUT*BW-1:0]      ofm_q;

  logic signed [BW-1:0]       win;
  logic signed [BW-1:0]       sum;
  logic signed [BW-1:0]       wr_val;
  logic signed [DW-1:0]       px_a;
  logic signed [DW-1:0]       px_b;
  logic signed [2*DW-1:0]     prod;
  logic [IFM_IW-1:0]          ifm_idx;
  logic [KER_IW-1:0]          ker_idx;
  logic [OFM_IW-1:0]          ofm_idx;

  // Full KxK window of the current (row, col, ch) triple, sign-extended per product.
  always_comb begin
    win     = '0;
    px_a    = '0;
    px_b    = '0;
    prod    = '0;
    ifm_idx = '0;
    ker_idx = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        ifm_idx = IFM_IW'(((32'(ch) * P + 32'(row) * STRIDE + i) * P
                           + 32'(col) * STRIDE + j) * DW);
        ker_idx = KER_IW'(((32'(ch) * K + i) * K + j) * DW);
        px_a    = bus.ifm[ifm_idx +: DW];
        px_b    = bus.kernel[ker_idx +: DW];
        prod    = px_a * px_b;
        win     = win + BW'(prod);
      end
    end
  end

  always_comb begin
    sum     = ((ch == '0) ? BW'($signed(bus.bias)) : acc) + win;
    ofm_idx = OFM_IW'((32'(row) * OUT + 32'(col)) * BW);
`ifdef CONV_RELU_EN
    wr_val  = sum[BW-1] ? '0 : sum;
`else
    wr_val  = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idle_q   <= 1'b1;
      finish_q <= 1'b0;
      row      <= '0;
      col      <= '0;
      ch       <= '0;
      acc      <= '0;
      ofm_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          finish_q <= 1'b0;
          if (bus.start) begin
            state  <= S_RUN;
            idle_q <= 1'b0;
          end
        end
        S_RUN: begin
          acc <= sum;
          if (ch == LAST_CH) begin
            ofm_q[ofm_idx +: BW] <= wr_val;
            ch <= '0;
            if (col == LAST_RC) begin
              col <= '0;
              if (row == LAST_RC) begin
                row      <= '0;
                state    <= S_DONE;
                finish_q <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            ch <= ch + 1'b1;
          end
        end
        S_DONE: begin
          finish_q <= 1'b0;
          idle_q   <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          idle_q   <= 1'b1;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ofm    = ofm_q;
  assign bus.idle   = idle_q;
  assign bus.finish = finish_q;
endmodule

// File: tb/tb_conv_mc_engine.sv
// Directed bench for conv_mc_engine: stride-1 instance plus a stride-2 instance
// sharing the same operand vectors.
module tb_conv_mc_engine;
  localparam int DW = 8, BW = 26, MS = 32, PD = 1, KS = 3, CH = 4;
  localparam int P = MS + 2 * PD;
  localparam int OUT1 = P - KS + 1;
  localparam int OUT2 = (P - KS) / 2 + 1;
  localparam int STEPS1 = OUT1 * OUT1 * CH;
  localparam int STEPS2 = OUT2 * OUT2 * CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH*P*P*DW-1:0]   ifm_v;
  logic [CH*KS*KS*DW-1:0] kern_v;
  logic [2*DW-1:0]        bias_v;

  int total = 0;
  int bad = 0;

  conv_mc_engine_if #(.DATA_WIDTH(DW), .BUF_WIDTH(BW), .MAP_SIZE(MS), .PADDING(PD),
                      .KERNEL_SIZE(KS), .STRIDE(1), .IN_CH(CH)) bus ();
  conv_mc_engine_if #(.DATA_WIDTH(DW), .BUF_WIDTH(BW), .MAP_SIZE(MS), .PADDING(PD),
                      .KERNEL_SIZE(KS), .STRIDE(2), .IN_CH(CH)) bus2 ();

  conv_mc_engine #(.DATA_WIDTH(DW), .BUF_WIDTH(BW), .MAP_SIZE(MS), .PADDING(PD),
                   .KERNEL_SIZE(KS), .STRIDE(1), .IN_CH(CH))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  conv_mc_engine #(.DATA_WIDTH(DW), .BUF_WIDTH(BW), .MAP_SIZE(MS), .PADDING(PD),
                   .KERNEL_SIZE(KS), .STRIDE(2), .IN_CH(CH))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus.ifm     = ifm_v;
  assign bus.kernel  = kern_v;
  assign bus.bias    = bias_v;
  assign bus2.ifm    = ifm_v;
  assign bus2.kernel = kern_v;
  assign bus2.bias   = bias_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w26(input int v);
    logic [31:0] t;
    t = v;
    return t & 32'h03FF_FFFF;
  endfunction

  function automatic logic [31:0] px(input int r, input int c);
    return {6'b0, bus.ofm[(r * OUT1 + c) * BW +: BW]};
  endfunction

  function automatic logic [31:0] px2(input int r, input int c);
    return {6'b0, bus2.ofm[(r * OUT2 + c) * BW +: BW]};
  endfunction

  function automatic logic fin(input bit sel);
    return sel ? bus2.finish : bus.finish;
  endfunction

  function automatic logic idl(input bit sel);
    return sel ? bus2.idle : bus.idle;
  endfunction

  // Straight-line reference for stride-1 pixel, including the optional clamp.
  function automatic int model_px(input int r, input int c);
    int a;
    logic signed [DW-1:0] x, k;
    logic signed [2*DW-1:0] b;
    b = bias_v;
    a = int'(b);
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < KS; i++)
        for (int j = 0; j < KS; j++) begin
          x = ifm_v[((ch * P + r + i) * P + c + j) * DW +: DW];
          k = kern_v[((ch * KS + i) * KS + j) * DW +: DW];
          a = a + int'(x) * int'(k);
        end
`ifdef CONV_RELU_EN
    if (a < 0) a = 0;
`endif
    return a;
  endfunction

  task automatic set_maps(input int iv, input int kv, input int bv);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < P; r++)
        for (int k = 0; k < P; k++)
          ifm_v[((c * P + r) * P + k) * DW +: DW] =
            (r >= PD && r < P - PD && k >= PD && k < P - PD) ? DW'(iv) : '0;
    for (int n = 0; n < CH * KS * KS; n++) kern_v[n * DW +: DW] = DW'(kv);
    bias_v = 16'(bv);
  endtask

  task automatic set_rand(input int bv);
    set_maps(0, 0, bv);
    for (int c = 0; c < CH; c++)
      for (int r = PD; r < P - PD; r++)
        for (int k = PD; k < P - PD; k++)
          ifm_v[((c * P + r) * P + k) * DW +: DW] = DW'(int'($urandom_range(252)) - 126);
    for (int n = 0; n < CH * KS * KS; n++) kern_v[n * DW +: DW] = DW'(int'($urandom_range(252)) - 126);
  endtask

  task automatic kick(input bit sel);
    @(negedge clk);
    if (sel) bus2.start = 1'b1; else bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    chk("busy_after_start", {31'b0, idl(sel)}, 32'd0);
  endtask

  // Counts edges after the start edge until finish; bounded so a stuck DUT cannot hang.
  task automatic wait_fin(input bit sel, input int exp, input string tag);
    int n = 0;
    while (fin(sel) !== 1'b1 && n < exp + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, exp);
    chk({tag, "_fin_hi"}, {31'b0, fin(sel)}, 32'd1);
    chk({tag, "_idle_lo"}, {31'b0, idl(sel)}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_fin_lo"}, {31'b0, fin(sel)}, 32'd0);
    chk({tag, "_idle_hi"}, {31'b0, idl(sel)}, 32'd1);
  endtask

  initial begin
    int nf;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    set_maps(1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", {31'b0, bus.idle}, 32'd1);
    chk("rst_finish", {31'b0, bus.finish}, 32'd0);
    chk("rst_ofm", {31'b0, |bus.ofm}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // T1: all-ones interior, unit kernels
    kick(0);
    wait_fin(0, STEPS1, "t1_lat");
    chk("t1_corner00", px(0, 0), 32'd16);
    chk("t1_edge05", px(0, 5), 32'd24);
    chk("t1_edge_left", px(7, 0), 32'd24);
    chk("t1_centre", px(10, 10), 32'd36);
    chk("t1_corner_br", px(31, 31), 32'd16);

    // T5a: start pulse mid-run has no effect
    kick(0);
    repeat (49) @(posedge clk);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_fin(0, STEPS1 - 50, "t5_ign_lat");
    chk("t5_ign_centre", px(16, 16), 32'd36);

    // T5b: reset at step 100
    kick(0);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_idle", {31'b0, bus.idle}, 32'd1);
    chk("t5_rst_finish", {31'b0, bus.finish}, 32'd0);
    chk("t5_rst_ofm", {31'b0, |bus.ofm}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    nf = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.finish) nf++;
    end
    chk("t5_no_finish", nf, 32'd0);
    kick(0);
    wait_fin(0, STEPS1, "t5_rerun_lat");
    chk("t5_rerun_centre", px(3, 4), 32'd36);
    chk("t5_rerun_corner", px(0, 31), 32'd16);

    // T3: extreme operands, no wrap
    set_maps(-128, -128, 32767);
    kick(0);
    wait_fin(0, STEPS1, "t3_lat");
    chk("t3_centre", px(15, 15), w26(622591));
    chk("t3_corner", px(31, 0), w26(294911));

    // T2: random signed data against the reference
    set_rand(-20000);
    kick(0);
    wait_fin(0, STEPS1, "t2_lat");
    nf = 0;
    for (int r = 0; r < OUT1; r++)
      for (int c = 0; c < OUT1; c++)
        if (px(r, c) !== w26(model_px(r, c))) begin
          if (nf < 5) $display("FAIL t2_px r=%0d c=%0d got=%0h exp=%0h",
                               r, c, px(r, c), w26(model_px(r, c)));
          nf++;
        end
    chk("t2_all_px_errors", nf, 32'd0);
    chk("t2_px_0_0", px(0, 0), w26(model_px(0, 0)));
    chk("t2_px_17_9", px(17, 9), w26(model_px(17, 9)));

    // T6: zero maps, negative bias
    set_maps(0, 5, -100);
    kick(0);
    wait_fin(0, STEPS1, "t6_lat");
`ifdef CONV_RELU_EN
    chk("t6_px_0_0", px(0, 0), 32'd0);
    chk("t6_px_20_11", px(20, 11), 32'd0);
    chk("t6_px_31_31", px(31, 31), 32'd0);
`else
    chk("t6_px_0_0", px(0, 0), 32'h03FF_FF9C);
    chk("t6_px_20_11", px(20, 11), 32'h03FF_FF9C);
    chk("t6_px_31_31", px(31, 31), 32'h03FF_FF9C);
`endif

    // T4: stride 2 instance
    set_maps(1, 1, 0);
    kick(1);
    wait_fin(1, STEPS2, "t4_lat");
    chk("t4_px_0_0", px2(0, 0), 32'd16);
    chk("t4_px_1_1", px2(1, 1), 32'd36);
    chk("t4_px_0_3", px2(0, 3), 32'd24);
    chk("t4_px_15_15", px2(15, 15), 32'd36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
